// File: rtl/io_uart.sv
// io_uart: memory-mapped UART on the CPU I/O bus.
// The TX path is a small FIFO feeding an 8N1 serializer. The RX path deserializes
// into a holding register with sticky status flags, which the CPU polls.
module io_uart #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter logic [7:0]  BASE_ADDR    = 8'h10,
  parameter int unsigned TX_DEPTH     = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_bus,
  output logic [7:0] o_bus,
  output logic       o_busNOE,
  input  logic       i_ioSelect,
  input  logic [7:0] i_ioAddress,
  input  logic       i_ioNOE,
  input  logic       i_ioNWE,
  input  logic       i_rx,
  output logic       o_tx
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned PW = $clog2(TX_DEPTH);
  localparam logic [CW-1:0] FULL_BIT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_BIT  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [7:0]    ADDR_STAT = BASE_ADDR + 8'd1;
  localparam logic [PW:0]   FIFO_FULL = (PW + 1)'(TX_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uartState_t;

  // ---------------- bus decode ----------------
  logic       addrData, addrStat, rdEn;
  logic       wrDataHit, wrStatHit, rdDataHit;
  logic [2:0] hitQ, hitQ2, hitPulse;
  logic [7:0] busQ;
  logic       wrDataPulse, wrStatPulse, rdDataPulse;
  logic [7:0] status, rxData;
  logic       txOverflow, frameErr, rxOverrun, rxValid, txEmpty, txFull;

  assign addrData  = (i_ioAddress == BASE_ADDR);
  assign addrStat  = (i_ioAddress == ADDR_STAT);
  assign rdEn      = i_ioSelect & ~i_ioNOE & (addrData | addrStat);
  assign wrDataHit = i_ioSelect & ~i_ioNWE & addrData;
  assign wrStatHit = i_ioSelect & ~i_ioNWE & addrStat;
  assign rdDataHit = i_ioSelect & ~i_ioNOE & addrData;

  assign status   = {2'b00, txOverflow, frameErr, rxOverrun, rxValid, txEmpty, txFull};
  assign o_busNOE = ~rdEn;
  assign o_bus    = rdEn ? (addrData ? rxData : status) : '0;

  // Register the strobe hits (and write data) so each assertion yields one pulse.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      hitQ  <= '0;
      hitQ2 <= '0;
      busQ  <= '0;
    end else begin
      hitQ  <= {rdDataHit, wrStatHit, wrDataHit};
      hitQ2 <= hitQ;
      busQ  <= i_bus;
    end
  end

  assign hitPulse    = hitQ & ~hitQ2;
  assign wrDataPulse = hitPulse[0];
  assign wrStatPulse = hitPulse[1];
  assign rdDataPulse = hitPulse[2];

  // ---------------- TX FIFO ----------------
  logic [7:0]    fifoMem [TX_DEPTH];
  logic [PW-1:0] wrPtr, rdPtr;
  logic [PW:0]   count;
  logic          pushOk, txPop;

  assign txFull = (count == FIFO_FULL);
  assign pushOk = wrDataPulse & ~txFull;

  // FIFO storage; no reset needed since occupancy is tracked by count.
  always_ff @(posedge i_clk) begin
    if (pushOk) fifoMem[wrPtr] <= busQ;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + 1'b1;
      if (txPop)  rdPtr <= rdPtr + 1'b1;
      case ({pushOk, txPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------- TX FSM ----------------
  uartState_t    txState, txNext;
  logic [CW-1:0] txCnt;
  logic [2:0]    txBit;
  logic [7:0]    txShift;
  logic          txTick, txLine;

  assign txTick  = (txCnt == '0);
  assign txEmpty = (count == '0) & (txState == IDLE);
  assign o_tx    = txLine;

  // TX state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) txState <= IDLE;
    else         txState <= txNext;
  end

  // TX next-state and FIFO pop.
  always_comb begin
    txNext = txState;
    txPop  = 1'b0;
    case (txState)
      IDLE:  if (count != '0) begin
               txNext = START;
               txPop  = 1'b1;
             end
      START: if (txTick) txNext = DATA;
      DATA:  if (txTick && txBit == 3'd7) txNext = STOP;
      STOP:  if (txTick) txNext = IDLE;
      default: txNext = IDLE;
    endcase
  end

  // TX datapath; the line register follows the current state one edge later,
  // which keeps every level exactly CLKS_PER_BIT cycles wide.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      txCnt   <= '0;
      txBit   <= '0;
      txShift <= '0;
      txLine  <= 1'b1;
    end else begin
      if (txNext != txState || txTick) txCnt <= FULL_BIT;
      else                             txCnt <= txCnt - 1'b1;
      if (txPop) txShift <= fifoMem[rdPtr];
      else if (txState == DATA && txTick) txShift <= {1'b0, txShift[7:1]};
      if (txState == DATA && txTick) txBit <= txBit + 1'b1;
      case (txState)
        START:   txLine <= 1'b0;
        DATA:    txLine <= txShift[0];
        default: txLine <= 1'b1;
      endcase
    end
  end

  // ---------------- RX path ----------------
  uartState_t    rxState, rxNext;
  logic [1:0]    rxSyncQ;
  logic          rxSync, rxTick, rxDone, rxFrameBad;
  logic [CW-1:0] rxCnt;
  logic [2:0]    rxBit;
  logic [7:0]    rxShift;

  assign rxSync = rxSyncQ[1];
  assign rxTick = (rxCnt == '0);

  // Two-flop synchronizer for the asynchronous serial input.
  always_ff @(posedge i_clk) begin
    if (i_reset) rxSyncQ <= 2'b11;
    else         rxSyncQ <= {rxSyncQ[0], i_rx};
  end

  // RX state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) rxState <= IDLE;
    else         rxState <= rxNext;
  end

  // RX next-state and frame completion decode.
  always_comb begin
    rxNext     = rxState;
    rxDone     = 1'b0;
    rxFrameBad = 1'b0;
    case (rxState)
      IDLE:  if (!rxSync) rxNext = START;
      START: if (rxTick) rxNext = rxSync ? IDLE : DATA;
      DATA:  if (rxTick && rxBit == 3'd7) rxNext = STOP;
      STOP:  if (rxTick) begin
               rxNext     = IDLE;
               rxDone     = rxSync;
               rxFrameBad = ~rxSync;
             end
      default: rxNext = IDLE;
    endcase
  end

  // RX counters and deserializer; the first reload is half a bit to hit mid-bit.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rxCnt   <= '0;
      rxBit   <= '0;
      rxShift <= '0;
    end else begin
      if (rxNext != rxState || rxTick) rxCnt <= (rxNext == START) ? HALF_BIT : FULL_BIT;
      else                             rxCnt <= rxCnt - 1'b1;
      if (rxState == DATA && rxTick) begin
        rxShift <= {rxSync, rxShift[7:1]};
        rxBit   <= rxBit + 1'b1;
      end
    end
  end

  // Holding register and sticky flags; a read in the completion cycle frees the slot.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rxData     <= '0;
      rxValid    <= 1'b0;
      rxOverrun  <= 1'b0;
      frameErr   <= 1'b0;
      txOverflow <= 1'b0;
    end else begin
      if (wrStatPulse) begin
        txOverflow <= 1'b0;
        frameErr   <= 1'b0;
        rxOverrun  <= 1'b0;
      end
      if (wrDataPulse && txFull) txOverflow <= 1'b1;
      if (rxFrameBad) frameErr <= 1'b1;
      if (rxDone) begin
        if (rxValid && !rdDataPulse) rxOverrun <= 1'b1;
        else begin
          rxData  <= rxShift;
          rxValid <= 1'b1;
        end
      end else if (rdDataPulse) begin
        rxValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_io_uart.sv
// Directed self-checking bench for io_uart with a fast baud rate.
module tb_io_uart;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] bus = '0;
  logic [7:0] ioAddress = '0;
  logic       ioSelect = 1'b0;
  logic       ioNOE = 1'b1;
  logic       ioNWE = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] obus;
  logic       busNOE;
  logic       tx;

  int checks = 0;
  int errors = 0;

  logic [7:0] txQ [$];

  io_uart #(.CLKS_PER_BIT(4), .BASE_ADDR(8'h10), .TX_DEPTH(4)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_bus       (bus),
    .o_bus       (obus),
    .o_busNOE    (busNOE),
    .i_ioSelect  (ioSelect),
    .i_ioAddress (ioAddress),
    .i_ioNOE     (ioNOE),
    .i_ioNWE     (ioNWE),
    .i_rx        (rx),
    .o_tx        (tx)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ioWrite(input logic [7:0] addr, input logic [7:0] data);
    @(negedge clk);
    ioSelect = 1'b1; ioAddress = addr; bus = data; ioNWE = 1'b0;
    repeat (3) @(negedge clk);
    ioSelect = 1'b0; ioNWE = 1'b1;
    @(negedge clk);
  endtask

  task automatic ioRead(input logic [7:0] addr, output logic [7:0] data, output logic noe);
    @(negedge clk);
    ioSelect = 1'b1; ioAddress = addr; ioNOE = 1'b0;
    @(negedge clk);
    data = obus;
    noe  = busNOE;
    repeat (2) @(negedge clk);
    ioSelect = 1'b0; ioNOE = 1'b1;
    @(negedge clk);
  endtask

  task automatic readCheck(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    logic [7:0] d;
    logic       n;
    ioRead(addr, d, n);
    checkVal(tag, d, exp);
    checkVal({tag, "_noeOn"}, n, 1'b0);
    checkVal({tag, "_noeOff"}, busNOE, 1'b1);
  endtask

  task automatic sendRx(input logic [7:0] data, input logic stopBit);
    logic [9:0] frame;
    frame = {stopBit, data, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = frame[i];
      repeat (4) @(negedge clk);
    end
    rx = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic captureA5();
    logic [9:0] txExp;
    logic [3:0] lv;
    int n;
    txExp = {1'b1, 8'hA5, 1'b0};
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx !== 1'b0 && n < 100);
    checkVal("txStart", tx, 1'b0);
    if (tx === 1'b0) begin
      for (int i = 0; i < 10; i++) begin
        for (int k = 0; k < 4; k++) begin
          lv[k] = tx;
          @(negedge clk);
        end
        checkVal($sformatf("txLevel%0d", i), lv, {4{txExp[i]}});
      end
      checkVal("txIdleAfter", tx, 1'b1);
    end
  endtask

  // Reference serial receiver decoding o_tx into txQ.
  initial begin
    logic [7:0] d;
    forever begin
      @(negedge tx);
      repeat (2) @(negedge clk);
      for (int b = 0; b < 8; b++) begin
        repeat (4) @(negedge clk);
        d[b] = tx;
      end
      repeat (4) @(negedge clk);
      if (tx === 1'b1) txQ.push_back(d);
    end
  end

  initial begin
    logic [7:0] d;
    logic       n;
    logic [7:0] exp2 [5];
    logic [7:0] got;
    exp2 = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44};

    // reset state
    repeat (3) @(negedge clk);
    checkVal("rstTx", tx, 1'b1);
    checkVal("rstNoe", busNOE, 1'b1);
    checkVal("rstBus", obus, 8'h00);
    reset = 1'b0;
    readCheck("rstStatus", 8'h11, 8'h02);
    ioRead(8'h12, d, n);
    checkVal("unmappedBus", d, 8'h00);
    checkVal("unmappedNoe", n, 1'b1);

    // single byte, level-by-level waveform
    fork
      ioWrite(8'h10, 8'hA5);
      captureA5();
    join
    readCheck("txDoneStatus", 8'h11, 8'h02);

    // FIFO fill and overflow while the line is busy
    repeat (10) @(negedge clk);
    txQ.delete();
    ioWrite(8'h10, 8'h00);
    ioWrite(8'h10, 8'h11);
    ioWrite(8'h10, 8'h22);
    ioWrite(8'h10, 8'h33);
    ioWrite(8'h10, 8'h44);
    ioWrite(8'h10, 8'h55);
    readCheck("overflowStatus", 8'h11, 8'h21);
    repeat (260) @(negedge clk);
    checkVal("txQSize", txQ.size(), 5);
    for (int i = 0; i < 5; i++) begin
      got = (i < txQ.size()) ? txQ[i] : 8'hxx;
      checkVal($sformatf("txByte%0d", i), got, exp2[i]);
    end
    ioWrite(8'h11, 8'h10);
    readCheck("ovfClearStatus", 8'h11, 8'h02);

    // receive one byte
    sendRx(8'h3C, 1'b1);
    readCheck("rxValidStatus", 8'h11, 8'h06);
    readCheck("rxData", 8'h10, 8'h3C);
    readCheck("rxClearedStatus", 8'h11, 8'h02);

    // overrun keeps the first byte
    sendRx(8'h55, 1'b1);
    sendRx(8'hAA, 1'b1);
    readCheck("overrunStatus", 8'h11, 8'h0E);
    readCheck("overrunData", 8'h10, 8'h55);
    readCheck("overrunAfterRead", 8'h11, 8'h0A);

    // bad stop bit
    sendRx(8'h99, 1'b0);
    readCheck("frameErrStatus", 8'h11, 8'h1A);
    ioWrite(8'h11, 8'h00);
    readCheck("flagsCleared", 8'h11, 8'h02);

    // one-cycle glitch
    @(negedge clk);
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    readCheck("glitchStatus", 8'h11, 8'h02);
    readCheck("glitchData", 8'h10, 8'h55);

    // long write strobe pushes one byte
    txQ.delete();
    @(negedge clk);
    ioSelect = 1'b1; ioAddress = 8'h10; bus = 8'h5A; ioNWE = 1'b0;
    repeat (20) @(negedge clk);
    ioSelect = 1'b0; ioNWE = 1'b1;
    repeat (100) @(negedge clk);
    checkVal("longStrobeCount", txQ.size(), 1);
    got = (txQ.size() > 0) ? txQ[0] : 8'hxx;
    checkVal("longStrobeByte", got, 8'h5A);
    readCheck("longStrobeStatus", 8'h11, 8'h02);

    // reset during TX data phase with a byte still queued
    ioWrite(8'h10, 8'h00);
    ioWrite(8'h10, 8'h00);
    repeat (2) @(negedge clk);
    checkVal("txInData", tx, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    checkVal("txAbort", tx, 1'b1);
    reset = 1'b0;
    readCheck("abortStatus", 8'h11, 8'h02);
    repeat (60) @(negedge clk);
    checkVal("txStaysIdle", tx, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
